// File: rtl/pe_multiweight.sv
// Systolic-array processing element with a local weight bank: daisy-chained weight
// loading, one MAC per active cycle against the selected bank entry, optional saturation.
module pe_multiweight #(
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned ACC_W    = 16,
  parameter int unsigned NWEIGHT  = 4,
  parameter int unsigned SIGNED   = 0,
  parameter int unsigned SATURATE = 1,
  localparam int unsigned WSEL_W  = (NWEIGHT > 1) ? $clog2(NWEIGHT) : 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              active,
  input  logic [DATA_W-1:0] datain,
  input  logic [ACC_W-1:0]  sumin,
  input  logic [WSEL_W-1:0] wsel,
  input  logic [DATA_W-1:0] win,
  input  logic              wwrite,
  output logic [ACC_W-1:0]  maccout,
  output logic [DATA_W-1:0] dataout,
  output logic [WSEL_W-1:0] wselout,
  output logic              activeout,
  output logic [DATA_W-1:0] wout,
  output logic              wwriteout,
  output logic              loaded,
  output logic              ovf
);

  localparam int unsigned CNT_W  = $clog2(NWEIGHT + 1);
  localparam int unsigned PROD_W = 2 * DATA_W;
  localparam int unsigned SUM_W  = ACC_W + 1;
  localparam bit          IsSigned = (SIGNED != 0);
  localparam bit          IsSat    = (SATURATE != 0);

  logic [DATA_W-1:0] w_q [NWEIGHT];
  logic [DATA_W-1:0] w_d [NWEIGHT];
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              wwrite_q;
  logic              bank_full;

  logic [ACC_W-1:0]  maccout_q, maccout_d;
  logic [DATA_W-1:0] dataout_q, dataout_d;
  logic [WSEL_W-1:0] wselout_q, wselout_d;
  logic              activeout_q;
  logic [DATA_W-1:0] wout_q, wout_d;
  logic              wwriteout_q, wwriteout_d;
  logic              ovf_q, ovf_d;

  logic [DATA_W-1:0] wsel_w;
  logic [PROD_W-1:0] op_a, op_b, prod;
  logic [SUM_W-1:0]  prod_ext, sum_ext, sum;
  logic              sum_ovf;
  logic [ACC_W-1:0]  sat_val, mac_res;

  assign bank_full = (cnt_q == CNT_W'(NWEIGHT));

  // Weight bank shift chain and load counter
  always_comb begin
    for (int i = 0; i < int'(NWEIGHT); i++) begin
      w_d[i] = w_q[i];
    end
    cnt_d       = cnt_q;
    wout_d      = wout_q;
    wwriteout_d = 1'b0;
    if (wwrite) begin
      w_d[0] = win;
      for (int i = 1; i < int'(NWEIGHT); i++) begin
        w_d[i] = w_q[i-1];
      end
      wout_d      = w_q[NWEIGHT-1];
      wwriteout_d = bank_full;
      if (!wwrite_q) begin
        cnt_d = CNT_W'(1);
      end else if (!bank_full) begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  // Out-of-range selects (non-power-of-2 depth) read as zero
  always_comb begin
    wsel_w = '0;
    for (int i = 0; i < int'(NWEIGHT); i++) begin
      if (wsel == WSEL_W'(i)) begin
        wsel_w = w_q[i];
      end
    end
  end

  // Extending both operands to PROD_W makes the low PROD_W bits correct in either mode
  always_comb begin
    op_a     = {{DATA_W{IsSigned & datain[DATA_W-1]}}, datain};
    op_b     = {{DATA_W{IsSigned & wsel_w[DATA_W-1]}}, wsel_w};
    prod     = op_a * op_b;
    prod_ext = {{(SUM_W - PROD_W){IsSigned & prod[PROD_W-1]}}, prod};
    sum_ext  = {IsSigned & sumin[ACC_W-1], sumin};
    sum      = sum_ext + prod_ext;
  end

  always_comb begin
    if (IsSigned) begin
      sum_ovf = sum[ACC_W] ^ sum[ACC_W-1];
      sat_val = sum[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
    end else begin
      sum_ovf = sum[ACC_W];
      sat_val = '1;
    end
    mac_res = (sum_ovf && IsSat) ? sat_val : sum[ACC_W-1:0];
  end

  always_comb begin
    maccout_d = maccout_q;
    dataout_d = dataout_q;
    wselout_d = wselout_q;
    ovf_d     = ovf_q;
    if (active) begin
      maccout_d = mac_res;
      dataout_d = datain;
      wselout_d = wsel;
      ovf_d     = ovf_q | sum_ovf;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < int'(NWEIGHT); i++) begin
        w_q[i] <= '0;
      end
      cnt_q       <= '0;
      wwrite_q    <= 1'b0;
      maccout_q   <= '0;
      dataout_q   <= '0;
      wselout_q   <= '0;
      activeout_q <= 1'b0;
      wout_q      <= '0;
      wwriteout_q <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      for (int i = 0; i < int'(NWEIGHT); i++) begin
        w_q[i] <= w_d[i];
      end
      cnt_q       <= cnt_d;
      wwrite_q    <= wwrite;
      maccout_q   <= maccout_d;
      dataout_q   <= dataout_d;
      wselout_q   <= wselout_d;
      activeout_q <= active;
      wout_q      <= wout_d;
      wwriteout_q <= wwriteout_d;
      ovf_q       <= ovf_d;
    end
  end

  assign maccout   = maccout_q;
  assign dataout   = dataout_q;
  assign wselout   = wselout_q;
  assign activeout = activeout_q;
  assign wout      = wout_q;
  assign wwriteout = wwriteout_q;
  assign loaded    = bank_full;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_pe_multiweight.sv
// Directed bench for pe_multiweight: default unsigned/saturating PE plus a wrapping and a
// signed instance driven by the same stimulus.
module tb_pe_multiweight;

  logic        clock = 1'b0;
  logic        reset;
  logic        active;
  logic [7:0]  datain;
  logic [15:0] sumin;
  logic [1:0]  wsel;
  logic [7:0]  win;
  logic        wwrite;

  logic [15:0] mac_d, mac_w, mac_s;
  logic [7:0]  dout_d, dout_w, dout_s;
  logic [1:0]  wso_d, wso_w, wso_s;
  logic        act_d, act_w, act_s;
  logic [7:0]  wout_d, wout_w, wout_s;
  logic        wwo_d, wwo_w, wwo_s;
  logic        ld_d, ld_w, ld_s;
  logic        ovf_d, ovf_w, ovf_s;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clock = ~clock;

  pe_multiweight #(.DATA_W(8), .ACC_W(16), .NWEIGHT(4), .SIGNED(0), .SATURATE(1)) u_dut (
    .clock(clock), .reset(reset), .active(active), .datain(datain), .sumin(sumin),
    .wsel(wsel), .win(win), .wwrite(wwrite), .maccout(mac_d), .dataout(dout_d),
    .wselout(wso_d), .activeout(act_d), .wout(wout_d), .wwriteout(wwo_d),
    .loaded(ld_d), .ovf(ovf_d)
  );

  pe_multiweight #(.DATA_W(8), .ACC_W(16), .NWEIGHT(4), .SIGNED(0), .SATURATE(0)) u_wrap (
    .clock(clock), .reset(reset), .active(active), .datain(datain), .sumin(sumin),
    .wsel(wsel), .win(win), .wwrite(wwrite), .maccout(mac_w), .dataout(dout_w),
    .wselout(wso_w), .activeout(act_w), .wout(wout_w), .wwriteout(wwo_w),
    .loaded(ld_w), .ovf(ovf_w)
  );

  pe_multiweight #(.DATA_W(8), .ACC_W(16), .NWEIGHT(4), .SIGNED(1), .SATURATE(1)) u_sgn (
    .clock(clock), .reset(reset), .active(active), .datain(datain), .sumin(sumin),
    .wsel(wsel), .win(win), .wwrite(wwrite), .maccout(mac_s), .dataout(dout_s),
    .wselout(wso_s), .activeout(act_s), .wout(wout_s), .wwriteout(wwo_s),
    .loaded(ld_s), .ovf(ovf_s)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    // Reset held for two edges while every other input is busy
    reset = 1'b1; active = 1'b1; datain = 8'd5; sumin = 16'd9; wsel = 2'd1;
    win = 8'hAA; wwrite = 1'b1;
    tick();
    tick();
    check("rst_maccout", mac_d, 0);
    check("rst_dataout", dout_d, 0);
    check("rst_wselout", wso_d, 0);
    check("rst_activeout", act_d, 0);
    check("rst_wout", wout_d, 0);
    check("rst_wwriteout", wwo_d, 0);
    check("rst_loaded", ld_d, 0);
    check("rst_ovf", ovf_d, 0);

    // Load 04,08,0C,10
    reset = 1'b0; active = 1'b0; wwrite = 1'b1; win = 8'h04;
    tick();
    check("ld1_loaded", ld_d, 0);
    check("ld1_wwriteout", wwo_d, 0);
    win = 8'h08; tick();
    win = 8'h0C; tick();
    check("ld3_loaded", ld_d, 0);
    win = 8'h10; tick();
    check("ld4_loaded", ld_d, 1);
    check("ld4_wwriteout", wwo_d, 0);

    // 5th load concurrent with MAC on w[3]=04 (pre-shift): 100 + 10*4
    win = 8'h14; active = 1'b1; wsel = 2'd3; datain = 8'd10; sumin = 16'd100;
    tick();
    check("mac1_maccout", mac_d, 140);
    check("mac1_dataout", dout_d, 10);
    check("mac1_wselout", wso_d, 3);
    check("mac1_activeout", act_d, 1);
    check("ld5_wout", wout_d, 8'h04);
    check("ld5_wwriteout", wwo_d, 1);
    check("ld5_loaded", ld_d, 1);

    // Idle edge: everything holds, activeout/wwriteout drop
    wwrite = 1'b0; active = 1'b0; datain = 8'd99; wsel = 2'd2; sumin = 16'd0;
    tick();
    check("idle_activeout", act_d, 0);
    check("idle_maccout", mac_d, 140);
    check("idle_dataout", dout_d, 10);
    check("idle_wwriteout", wwo_d, 0);
    check("idle_wout", wout_d, 8'h04);
    check("idle_loaded", ld_d, 1);

    // Bank is now {14,10,0C,08}; w[0]=0x14=20: 1 + 2*20
    active = 1'b1; wsel = 2'd0; datain = 8'd2; sumin = 16'd1;
    tick();
    check("mac2_maccout", mac_d, 41);
    check("mac2_wselout", wso_d, 0);
    check("mac2_ovf", ovf_d, 0);

    // New burst of FF: first edge displaces 08 with wwriteout=1 since cnt was full
    active = 1'b0; wwrite = 1'b1; win = 8'hFF;
    tick();
    check("nb1_wout", wout_d, 8'h08);
    check("nb1_wwriteout", wwo_d, 1);
    check("nb1_loaded", ld_d, 0);
    tick();
    check("nb2_wout", wout_d, 8'h0C);
    check("nb2_wwriteout", wwo_d, 0);
    tick();
    tick();
    check("nb4_loaded", ld_d, 1);

    // Overflow: FF*FF + FFFF
    wwrite = 1'b0; active = 1'b1; wsel = 2'd2; datain = 8'hFF; sumin = 16'hFFFF;
    tick();
    check("sat_maccout", mac_d, 16'hFFFF);
    check("sat_ovf", ovf_d, 1);
    check("wrap_maccout", mac_w, 16'hFE00);
    check("wrap_ovf", ovf_w, 1);
    check("sgn_m1xm1_maccout", mac_s, 16'h0000);
    check("sgn_m1xm1_ovf", ovf_s, 0);
    active = 1'b0;
    tick();
    check("sat_ovf_sticky", ovf_d, 1);
    check("sat_maccout_hold", mac_d, 16'hFFFF);

    // Signed: w[0]=FE (-2), datain=3, sumin=5 -> -1
    wwrite = 1'b1; win = 8'hFE;
    tick();
    wwrite = 1'b0; active = 1'b1; wsel = 2'd0; datain = 8'd3; sumin = 16'd5;
    tick();
    check("sgn_maccout", mac_s, 16'hFFFF);
    check("sgn_ovf", ovf_s, 0);
    check("uns_fe_maccout", mac_d, 16'h02FF);
    // Signed negative saturation: -32768 + (-2)
    datain = 8'd1; sumin = 16'h8000;
    tick();
    check("sgn_sat_maccout", mac_s, 16'h8000);
    check("sgn_sat_ovf", ovf_s, 1);
    check("uns_80fe_maccout", mac_d, 16'h80FE);

    // Reset mid-burst
    active = 1'b0; wwrite = 1'b1; win = 8'h11;
    tick();
    win = 8'h22;
    tick();
    reset = 1'b1; active = 1'b1;
    tick();
    reset = 1'b0; active = 1'b0; wwrite = 1'b0;
    check("mid_loaded", ld_d, 0);
    check("mid_ovf", ovf_d, 0);
    check("mid_sgn_ovf", ovf_s, 0);
    check("mid_maccout", mac_d, 0);
    active = 1'b1; wsel = 2'd1; datain = 8'd5; sumin = 16'd7;
    tick();
    check("zb1_maccout", mac_d, 7);
    wsel = 2'd3; datain = 8'hFF;
    tick();
    check("zb3_maccout", mac_d, 7);
    check("zb3_ovf", ovf_d, 0);
    active = 1'b0; wwrite = 1'b1; win = 8'h33;
    tick();
    check("post_wout", wout_d, 0);
    check("post_wwriteout", wwo_d, 0);
    check("post_loaded", ld_d, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
